// File: rtl/sr8_pkg.sv
// Shared types and constants for the 8-bit shift-register sequencer.
package sr8_pkg;

  localparam int W     = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_WRV = 2'b11;

endpackage

// File: rtl/sr8_seq_ctrl.sv
// Sequencer owning the shift-register/mux datapath: serialises a byte, scans it
// back through the Z mux, or both with a compare. Every output is registered.
module sr8_seq_ctrl
  import sr8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [W-1:0]     din,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     rdata,
  output logic             match,
  output logic             sr_en,
  output logic             sr_s,
  output logic [SEL_W-1:0] sel,
  input  logic             z
);

  localparam logic [SEL_W-1:0] CNT_LAST = SEL_W'(W - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     shadow_q, shadow_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     rdata_q, rdata_d;
  logic             match_q, match_d;
  logic             sr_en_q, sr_en_d;
  logic             sr_s_q, sr_s_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [W-1:0]     rdata_scan;

  // Outputs are computed one cycle ahead, for the state being entered, so the
  // registered pins are already valid during the cycle they apply to.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    op_d       = op_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rdata_d    = rdata_q;
    match_d    = match_q;
    sr_en_d    = sr_en_q;
    sr_s_d     = sr_s_q;
    sel_d      = sel_q;
    rdata_scan = rdata_q;
    rdata_scan[cnt_q] = z;

    unique case (state_q)
      IDLE: begin
        if (start && cmd != CMD_NOP) begin
          shadow_d = din;
          op_d     = cmd;
          cnt_d    = '0;
          busy_d   = 1'b1;
          match_d  = 1'b0;
          if (cmd == CMD_RD) begin
            state_d = SCAN;
            sel_d   = '0;
            rdata_d = '0;
          end else begin
            state_d = SHIFT;
            sr_en_d = 1'b1;
            sr_s_d  = din[W-1];
          end
        end
      end

      SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d  = cnt_q + 1'b1;
          sr_s_d = shadow_q[CNT_LAST - cnt_d];
        end else begin
          cnt_d   = '0;
          sr_en_d = 1'b0;
          sr_s_d  = 1'b0;
          if (op_q == CMD_WRV) begin
            state_d = SCAN;
            sel_d   = '0;
            rdata_d = '0;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = 1'b0;
          end
        end
      end

      SCAN: begin
        rdata_d = rdata_scan;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
          sel_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          sel_d   = '0;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = (op_q == CMD_WRV) && (rdata_scan == shadow_q);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      op_q     <= CMD_NOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      match_q  <= 1'b0;
      sr_en_q  <= 1'b0;
      sr_s_q   <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      match_q  <= match_d;
      sr_en_q  <= sr_en_d;
      sr_s_q   <= sr_s_d;
      sel_q    <= sel_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign match = match_q;
  assign sr_en = sr_en_q;
  assign sr_s  = sr_s_q;
  assign sel   = sel_q;

endmodule

// File: tb/tb_sr8_seq_ctrl.sv
// Bench for sr8_seq_ctrl: table of operations against a behavioural
// shift-register/mux datapath, plus hand sequences for protocol corners.
module tb_sr8_seq_ctrl;
  import sr8_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = CMD_NOP;
  logic [7:0] din = 8'h00;
  logic       busy, done, match, sr_en, sr_s, z;
  logic [7:0] rdata;
  logic [2:0] sel;

  logic [7:0] dp_q = 8'h00;
  logic       z_force = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Datapath model: serial-in shift register with an 8:1 bit-select mux.
  always_ff @(posedge clk) if (sr_en) dp_q <= {dp_q[6:0], sr_s};
  assign z = z_force ? 1'b0 : dp_q[sel];

  sr8_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .din(din),
    .busy(busy), .done(done), .rdata(rdata), .match(match),
    .sr_en(sr_en), .sr_s(sr_s), .sel(sel), .z(z)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] din;
    logic       fz;     // hold z stuck at 0 for the whole operation
    logic       inj;    // present a second start while busy
    int         lat;
    logic [7:0] rdata;
    logic       match;
    logic [7:0] q;
  } vec_t;

  vec_t vecs[7];

  task automatic run_op(input vec_t v, input string tag);
    int lat = 0;
    int en_cnt = 0;
    int scan_n = 0;
    int sel_bad = 0;
    logic [7:0] sbits = 8'h00;
    @(negedge clk);
    start = 1'b1; cmd = v.cmd; din = v.din; z_force = v.fz;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, " busy_first"}, 32'(busy), 32'd1);
        check({tag, " match_clr"}, 32'(match), 32'd0);
      end
      if (v.inj && k == 4) begin start = 1'b1; cmd = CMD_WRV; din = 8'hFF; end
      if (v.inj && k == 5) start = 1'b0;
      if (done) begin lat = k; break; end
      if (sr_en) begin
        en_cnt++;
        sbits = {sbits[6:0], sr_s};
      end else if (busy) begin
        if (sel !== 3'(scan_n)) sel_bad++;
        scan_n++;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " sr_en_cycles"}, 32'(en_cnt), (v.cmd == CMD_RD) ? 32'd0 : 32'd8);
    check({tag, " sr_s_seq"}, 32'(sbits), (v.cmd == CMD_RD) ? 32'd0 : 32'(v.din));
    check({tag, " scan_cycles"}, 32'(scan_n), (v.cmd == CMD_WR) ? 32'd0 : 32'd8);
    check({tag, " sel_steps"}, 32'(sel_bad), 32'd0);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " sel_at_done"}, 32'(sel), 32'd0);
    check({tag, " rdata"}, 32'(rdata), 32'(v.rdata));
    check({tag, " match"}, 32'(match), 32'(v.match));
    check({tag, " q"}, 32'(dp_q), 32'(v.q));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " match_hold"}, 32'(match), 32'(v.match));
    z_force = 1'b0;
  endtask

  initial begin
    int seen;

    vecs[0] = '{CMD_WR,  8'hA5, 1'b0, 1'b0,  9, 8'h00, 1'b0, 8'hA5};
    vecs[1] = '{CMD_RD,  8'h00, 1'b0, 1'b0,  9, 8'hA5, 1'b0, 8'hA5};
    vecs[2] = '{CMD_WRV, 8'h3C, 1'b0, 1'b0, 17, 8'h3C, 1'b1, 8'h3C};
    vecs[3] = '{CMD_WRV, 8'h3C, 1'b1, 1'b0, 17, 8'h00, 1'b0, 8'h3C};
    vecs[4] = '{CMD_WR,  8'h5A, 1'b0, 1'b1,  9, 8'h00, 1'b0, 8'h5A};
    vecs[5] = '{CMD_RD,  8'h00, 1'b0, 1'b0,  9, 8'h5A, 1'b0, 8'h5A};
    vecs[6] = '{CMD_WRV, 8'hC3, 1'b0, 1'b0, 17, 8'hC3, 1'b1, 8'hC3};

    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rdata", 32'(rdata), 32'd0);
    check("rst match", 32'(match), 32'd0);
    check("rst sr_en", 32'(sr_en), 32'd0);
    check("rst sr_s", 32'(sr_s), 32'd0);
    check("rst sel", 32'(sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // match from the last verify holds; a nop start neither runs nor clears it
    repeat (3) @(negedge clk);
    check("match_idle_hold", 32'(match), 32'd1);
    start = 1'b1; cmd = CMD_NOP; din = 8'h77;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    check("nop_no_activity", 32'(seen), 32'd0);
    check("nop_match_kept", 32'(match), 32'd1);

    // start presented only during the DONE cycle is dropped
    start = 1'b1; cmd = CMD_WR; din = 8'h66;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check("dstart_done_seen", 32'(seen), 32'd1);
    start = 1'b1; cmd = CMD_WR; din = 8'h99;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    check("dstart_ignored", 32'(seen), 32'd0);
    check("dstart_q", 32'(dp_q), 32'h66);

    // asynchronous reset in shift cycle 4
    start = 1'b1; cmd = CMD_WRV; din = 8'h18;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst busy", 32'(busy), 32'd1);
    check("pre_rst sr_en", 32'(sr_en), 32'd1);
    check("pre_rst rdata", 32'(rdata), 32'hC3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst sr_en", 32'(sr_en), 32'd0);
    check("mid_rst sr_s", 32'(sr_s), 32'd0);
    check("mid_rst sel", 32'(sel), 32'd0);
    check("mid_rst rdata", 32'(rdata), 32'd0);
    check("mid_rst match", 32'(match), 32'd0);
    check("mid_rst done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check("in_rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    run_op('{CMD_WRV, 8'h81, 1'b0, 1'b0, 17, 8'h81, 1'b1, 8'h81}, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
